// File: rtl/id_stage_ctrl.sv
// IF/ID register controller: holds one fetch, issues to EX, load-use bubbles, redirect flush.
// Optional perf counters (stall_cnt, flush_cnt) under `define ID_PERF_CNT_EN.
module id_stage_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter logic [31:0] NOP_INSTR    = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_valid,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc,
    output logic        if_ready,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    input  logic        ex_ready,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    input  logic        redirect,
`ifdef ID_PERF_CNT_EN
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt,
`endif
    output logic        id_issue,
    output logic        id_bubble
);

    localparam logic [3:0] FLUSH_LD = 4'(FLUSH_CYCLES);

    logic [3:0] drop;
    logic       use1;
    logic       use2;
    logic       hit1;
    logic       hit2;
    logic       hazard;
    logic       dropping;
    logic       accept;

    always_comb begin
        use1 = 1'b0;
        use2 = 1'b0;
        case (id_instr[6:0])
            7'b0110011: begin use1 = 1'b1; use2 = 1'b1; end
            7'b0100011: begin use1 = 1'b1; use2 = 1'b1; end
            7'b1100011: begin use1 = 1'b1; use2 = 1'b1; end
            7'b0010011: use1 = 1'b1;
            7'b0000011: use1 = 1'b1;
            7'b1100111: use1 = 1'b1;
            default:    ;
        endcase
    end

    assign hit1   = use1 && (id_instr[19:15] == ex_rd);
    assign hit2   = use2 && (id_instr[24:20] == ex_rd);
    assign hazard = id_valid && ex_mem_read && (ex_rd != 5'd0) && (hit1 || hit2);

    assign id_issue  = id_valid && !hazard && ex_ready && !redirect;
    assign id_bubble = id_valid && hazard && !redirect;
    assign dropping  = (drop != 4'd0);
    assign if_ready  = !id_valid || id_issue || dropping || redirect;
    assign accept    = if_valid && if_ready && !dropping && !redirect;

    always_ff @(posedge clk) begin
        if (rst) begin
            id_valid <= 1'b0;
            id_instr <= NOP_INSTR;
            id_pc    <= 32'd0;
            drop     <= 4'd0;
        end else if (redirect) begin
            // wrong-path fetch in this cycle is discarded too
            id_valid <= 1'b0;
            id_instr <= NOP_INSTR;
            drop     <= FLUSH_LD;
        end else begin
            if (dropping && if_valid)
                drop <= drop - 4'd1;
            if (accept) begin
                id_valid <= 1'b1;
                id_instr <= if_instr;
                id_pc    <= if_pc;
            end else if (id_issue) begin
                id_valid <= 1'b0;
                id_instr <= NOP_INSTR;
            end
        end
    end

`ifdef ID_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else begin
            if (id_bubble && (stall_cnt != 32'hFFFFFFFF))
                stall_cnt <= stall_cnt + 32'd1;
            if (redirect && (flush_cnt != 32'hFFFFFFFF))
                flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif

endmodule
